// File: rtl/convolution_layer.sv
// Streaming 2-D "valid" convolution: a shared line buffer feeds EngineCount parallel KxK
// MAC engines, and each engine's result is requantised (shift, optional ReLU, saturate).
module convolution_layer #(
    parameter int MaxMatrixSize = 10,
    parameter int KernelSize    = 3,
    parameter int EngineCount   = 2,
    parameter int Bits          = 8
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   start_i,
    input  logic [EngineCount-1:0][KernelSize*KernelSize-1:0][Bits-1:0] kernel_weights_i,
    input  logic [15:0]                                            reg_bcfg1_i,
    input  logic [15:0]                                            reg_bcfg2_i,
    input  logic [15:0]                                            reg_cprm1_i,
    input  logic                                                   has_data_i,
    input  logic                                                   req_next_i,
    input  logic signed [Bits-1:0]                                 activation_data_i,
    output logic                                                   used_data_o,
    output logic                                                   conv_valid_o,
    output logic [EngineCount-1:0][Bits-1:0]                       data_o,
    output logic                                                   conv_done_o,
    output logic                                                   conv_running_o,
    input  logic                                                   assert_on_i
);

    localparam int KK   = KernelSize * KernelSize;
    localparam int AccW = 2 * Bits + $clog2(KK);
    localparam int CntW = $clog2(MaxMatrixSize + 1);
    localparam logic signed [AccW-1:0] SatMax = AccW'(2 ** (Bits - 1) - 1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    function automatic logic signed [AccW-1:0] mul_ext(input logic signed [Bits-1:0] a,
                                                       input logic signed [Bits-1:0] b);
        logic signed [2*Bits-1:0] p;
        p = $signed({{Bits{a[Bits-1]}}, a}) * $signed({{Bits{b[Bits-1]}}, b});
        return {{(AccW - 2 * Bits){p[2*Bits-1]}}, p};
    endfunction

    function automatic logic [Bits-1:0] requant(input logic signed [AccW-1:0] acc,
                                                input logic [4:0] sh,
                                                input logic relu);
        logic signed [AccW-1:0] y;
        y = acc >>> sh;
        if (relu && y[AccW-1]) y = '0;
        if (y > SatMax)      y = SatMax;
        else if (y < SatMin) y = SatMin;
        return y[Bits-1:0];
    endfunction

    // Run configuration, frozen at start
    logic [CntW-1:0] m_q;
    logic [7:0]      eng_q;
    logic [4:0]      shift_q;
    logic            relu_q;
    logic [3:0]      stride_q;
    logic [EngineCount-1:0][KK-1:0][Bits-1:0] weights_q;

    logic [CntW-1:0] row_q, col_q;
    logic [3:0]      row_ph_q, col_ph_q;
    logic            pix_left_q;
    logic            vld_p0, last_p0, last_p1;

    logic signed [Bits-1:0] lb_q   [KernelSize-1][MaxMatrixSize];
    logic signed [Bits-1:0] win_p0 [KernelSize][KernelSize];
    logic signed [Bits-1:0] col_v  [KernelSize];

    logic            cfg_legal, start_ok, accept, last_pix, hit, row_ready, col_ready;
    logic [3:0]      stride_m1;

    assign cfg_legal = (reg_bcfg2_i >= 16'(KernelSize)) && (reg_bcfg2_i <= 16'(MaxMatrixSize))
                    && (reg_bcfg1_i[7:0] != 8'd0) && (reg_bcfg1_i[7:0] <= 8'(EngineCount));
    assign start_ok  = start_i && !conv_running_o && !conv_done_o;
    assign accept    = conv_running_o && has_data_i && req_next_i && pix_left_q;
    assign used_data_o = accept;
    assign last_pix  = (row_q == m_q - CntW'(1)) && (col_q == m_q - CntW'(1));
    assign row_ready = row_q >= CntW'(KernelSize - 1);
    assign col_ready = col_q >= CntW'(KernelSize - 1);
    assign hit       = row_ready && col_ready && (row_ph_q == 4'd0) && (col_ph_q == 4'd0);
    assign stride_m1 = (stride_q == 4'd0) ? 4'd0 : stride_q - 4'd1;

    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            m_q       <= reg_bcfg2_i[CntW-1:0];
            eng_q     <= reg_bcfg1_i[7:0];
            shift_q   <= reg_bcfg1_i[12:8];
            relu_q    <= reg_cprm1_i[0];
            stride_q  <= reg_cprm1_i[9:6];
            weights_q <= kernel_weights_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conv_running_o <= 1'b0;
            conv_done_o    <= 1'b0;
            conv_valid_o   <= 1'b0;
            pix_left_q     <= 1'b0;
            row_q          <= '0;
            col_q          <= '0;
            row_ph_q       <= '0;
            col_ph_q       <= '0;
            vld_p0         <= 1'b0;
            last_p0        <= 1'b0;
            last_p1        <= 1'b0;
        end else begin
            vld_p0       <= accept && hit;
            last_p0      <= accept && last_pix;
            last_p1      <= last_p0;
            conv_valid_o <= vld_p0;
            conv_done_o  <= last_p1 || (start_ok && !cfg_legal);
            if (start_ok && cfg_legal) begin
                conv_running_o <= 1'b1;
                pix_left_q     <= 1'b1;
                row_q          <= '0;
                col_q          <= '0;
                row_ph_q       <= '0;
                col_ph_q       <= '0;
            end else if (last_p1) begin
                conv_running_o <= 1'b0;
            end
            if (accept) begin
                // Stride phases only start counting once a full window fits in that axis
                if (col_q == m_q - CntW'(1)) begin
                    col_q    <= '0;
                    col_ph_q <= '0;
                    row_q    <= row_q + CntW'(1);
                    row_ph_q <= !row_ready ? 4'd0 : (row_ph_q == stride_m1) ? 4'd0 : row_ph_q + 4'd1;
                end else begin
                    col_q    <= col_q + CntW'(1);
                    col_ph_q <= !col_ready ? 4'd0 : (col_ph_q == stride_m1) ? 4'd0 : col_ph_q + 4'd1;
                end
                if (last_pix) pix_left_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < KernelSize - 1; i++) col_v[i] = lb_q[i][col_q];
        col_v[KernelSize-1] = activation_data_i;
    end

    // Stage p0: line buffer shifts one row up per column, window shifts one column left
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < KernelSize - 1; i++)
                for (int c = 0; c < MaxMatrixSize; c++) lb_q[i][c] <= '0;
            for (int i = 0; i < KernelSize; i++)
                for (int j = 0; j < KernelSize; j++) win_p0[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < KernelSize - 2; i++) lb_q[i][col_q] <= lb_q[i+1][col_q];
            lb_q[KernelSize-2][col_q] <= activation_data_i;
            for (int i = 0; i < KernelSize; i++) begin
                for (int j = 0; j < KernelSize - 1; j++) win_p0[i][j] <= win_p0[i][j+1];
                win_p0[i][KernelSize-1] <= col_v[i];
            end
        end
    end

    logic signed [AccW-1:0]            acc_p1 [EngineCount];
    logic [EngineCount-1:0][Bits-1:0]  res_p1;

    always_comb begin
        res_p1 = '0;
        for (int e = 0; e < EngineCount; e++) begin
            acc_p1[e] = '0;
            for (int i = 0; i < KernelSize; i++)
                for (int j = 0; j < KernelSize; j++)
                    acc_p1[e] = acc_p1[e] + mul_ext(weights_q[e][i*KernelSize+j], win_p0[i][j]);
            if (8'(e) < eng_q) res_p1[e] = requant(acc_p1[e], shift_q, relu_q);
        end
    end

    // Stage p1: registered, requantised result per engine
    always_ff @(posedge clk_i) begin
        if (rst_i)       data_o <= '0;
        else if (vld_p0) data_o <= res_p1;
    end

    always_ff @(posedge clk_i) begin
        if (assert_on_i && !rst_i) begin
            if (used_data_o) assert (conv_running_o);
            if (conv_running_o)
                assert ((m_q >= CntW'(KernelSize)) && (m_q <= CntW'(MaxMatrixSize))
                        && (eng_q != 8'd0) && (eng_q <= 8'(EngineCount)));
            if (conv_valid_o) assert (!$isunknown(data_o));
        end
    end

endmodule

// File: tb/tb_convolution_layer.sv
// Directed + randomized bench for convolution_layer; expected outputs come from a
// direct sliding-window model over the whole input matrix.
module tb_convolution_layer;

    localparam int MMAX = 10;
    localparam int K    = 3;
    localparam int E    = 2;
    localparam int B    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst, start, has_data, req_next, assert_on;
    logic [E-1:0][K*K-1:0][B-1:0] w;
    logic [15:0]                 bcfg1, bcfg2, cprm1;
    logic signed [B-1:0]         act;
    logic                        used, vld, done, running;
    logic [E-1:0][B-1:0]         dout;

    convolution_layer #(.MaxMatrixSize(MMAX), .KernelSize(K), .EngineCount(E), .Bits(B)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .kernel_weights_i(w),
        .reg_bcfg1_i(bcfg1), .reg_bcfg2_i(bcfg2), .reg_cprm1_i(cprm1),
        .has_data_i(has_data), .req_next_i(req_next), .activation_data_i(act),
        .used_data_o(used), .conv_valid_o(vld), .data_o(dout), .conv_done_o(done),
        .conv_running_o(running), .assert_on_i(assert_on)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int wt [E][K*K];
    int xs [MMAX*MMAX];
    int acc_cyc [MMAX*MMAX];
    int exp_trig[$];
    int exp_v0[$];
    int exp_v1[$];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void build_model(input int m, input int s, input int sh,
                                        input int relu, input int eng);
        int n, acc, y;
        exp_trig.delete();
        exp_v0.delete();
        exp_v1.delete();
        n = (m - K) / s + 1;
        for (int oy = 0; oy < n; oy++) begin
            for (int ox = 0; ox < n; ox++) begin
                exp_trig.push_back((oy * s + K - 1) * m + ox * s + K - 1);
                for (int e = 0; e < E; e++) begin
                    acc = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            acc += wt[e][i*K+j] * xs[(oy*s+i)*m + ox*s + j];
                    y = acc >>> sh;
                    if (relu != 0 && y < 0) y = 0;
                    y = sat(y);
                    if (e >= eng) y = 0;
                    if (e == 0) exp_v0.push_back(y);
                    else        exp_v1.push_back(y);
                end
            end
        end
    endfunction

    task automatic set_weights(input bit rnd);
        int spec1 [K*K] = '{10, -10, 20, -20, 30, -30, 40, -40, 50};
        for (int k = 0; k < K*K; k++) begin
            wt[0][k] = rnd ? int'($urandom_range(0, 255)) - 128 : k + 1;
            wt[1][k] = rnd ? int'($urandom_range(0, 255)) - 128 : spec1[k];
        end
        for (int e = 0; e < E; e++)
            for (int k = 0; k < K*K; k++) w[e][k] = wt[e][k][B-1:0];
    endtask

    task automatic set_data(input int m, input int pat);
        for (int i = 0; i < m*m; i++)
            xs[i] = (pat == 0) ? i : (pat == 1) ? -i : int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic set_cfg(input int m, input int s, input int sh, input int relu, input int eng);
        int rsv, es;
        rsv = int'($urandom_range(0, 31));
        es  = (s == 1 && $urandom_range(0, 1) == 1) ? 0 : s;
        bcfg1 = {3'b000, sh[4:0], eng[7:0]};
        bcfg2 = m[15:0];
        cprm1 = {6'b000000, es[3:0], rsv[4:0], relu[0]};
    endtask

    task automatic run_conv(input int m, input int s, input int sh, input int relu,
                            input int eng, input bit rand_hs, input bit poke,
                            input int abort_at, input string tag);
        int n_acc, n_out, last_vld, nn, trig, e0, e1, last_e0, last_e1;
        bit got_done;
        n_acc = 0; n_out = 0; last_vld = -1; got_done = 0; last_e0 = 0; last_e1 = 0;
        nn = ((m - K) / s + 1) * ((m - K) / s + 1);
        for (int i = 0; i < MMAX*MMAX; i++) acc_cyc[i] = -1000;
        build_model(m, s, sh, relu, eng);
        set_cfg(m, s, sh, relu, eng);
        has_data = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " running after start"}, running, 1);
        for (int t = 0; t < 4000 && !got_done; t++) begin
            if (vld) begin
                n_out++;
                last_vld = cyc;
                if (exp_trig.size() == 0) begin
                    check({tag, " extra output"}, n_out, nn);
                end else begin
                    trig = exp_trig.pop_front();
                    e0 = exp_v0.pop_front();
                    e1 = exp_v1.pop_front();
                    last_e0 = e0;
                    last_e1 = e1;
                    check($sformatf("%s latency out%0d", tag, n_out), cyc - acc_cyc[trig], 2);
                    check($sformatf("%s e0 out%0d", tag, n_out), $signed(dout[0]), e0);
                    check($sformatf("%s e1 out%0d", tag, n_out), $signed(dout[1]), e1);
                end
            end
            if (done) begin
                got_done = 1'b1;
                check({tag, " done one cycle after last output"}, cyc, last_vld + 1);
                check({tag, " running low at done"}, running, 0);
                check({tag, " output count"}, n_out, nn);
                check({tag, " pixel count"}, n_acc, m*m);
            end else begin
                if (poke && t == 0) begin
                    bcfg2 = 16'h0010;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                has_data = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
                req_next = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
                act = (n_acc < m*m) ? xs[n_acc][B-1:0] : '0;
                #1;
                if (used) begin
                    if (n_acc < MMAX*MMAX) acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
                if (abort_at > 0 && n_acc == abort_at) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check({tag, " abort valid"}, vld, 0);
                    check({tag, " abort data"}, dout, 0);
                    check({tag, " abort running"}, running, 0);
                    begin
                        int bad;
                        bad = 0;
                        has_data = 1'b1;
                        req_next = 1'b1;
                        for (int k = 0; k < 10; k++) begin
                            #1;
                            if (done || vld || used) bad++;
                            step();
                        end
                        check({tag, " quiet after abort"}, bad, 0);
                    end
                    return;
                end
                step();
            end
        end
        if (!got_done) begin
            check({tag, " done seen within budget"}, got_done, 1);
        end else begin
            has_data = 1'b1;
            req_next = 1'b1;
            step();
            #1;
            check({tag, " done is a pulse"}, done, 0);
            check({tag, " idle after done"}, running, 0);
            check({tag, " no pop after done"}, used, 0);
            check({tag, " data_o holds e0"}, $signed(dout[0]), last_e0);
            check({tag, " data_o holds e1"}, $signed(dout[1]), last_e1);
        end
    endtask

    task automatic run_illegal(input int m, input int eng, input string tag);
        set_cfg(m, 1, 0, 0, eng);
        has_data = 1'b1;
        req_next = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check({tag, " done pulse"}, done, 1);
        check({tag, " never running"}, running, 0);
        check({tag, " no pop"}, used, 0);
        step();
        check({tag, " done cleared"}, done, 0);
        check({tag, " still idle"}, running, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; has_data = 1'b1; req_next = 1'b1; assert_on = 1'b1;
        act = '0; bcfg1 = '0; bcfg2 = '0; cprm1 = '0; w = '0;
        repeat (3) step();
        #1;
        check("reset valid", vld, 0);
        check("reset done", done, 0);
        check("reset running", running, 0);
        check("reset used", used, 0);
        check("reset data", dout, 0);
        rst = 1'b0;
        step();

        set_weights(1'b0);
        set_data(5, 0);
        run_conv(5, 1, 2, 0, 2, 1'b0, 1'b0, 0, "ramp shift2");
        run_conv(5, 1, 0, 0, 2, 1'b0, 1'b0, 0, "ramp shift0 saturate");
        set_data(5, 1);
        run_conv(5, 1, 2, 0, 2, 1'b0, 1'b0, 0, "neg ramp");
        run_conv(5, 1, 2, 1, 2, 1'b0, 1'b0, 0, "neg ramp relu");
        set_data(5, 0);
        run_conv(5, 1, 2, 0, 2, 1'b0, 1'b1, 0, "cfg change after start");
        set_data(5, 2);
        run_conv(5, 2, 1, 0, 2, 1'b1, 1'b0, 0, "stride2 handshake");

        set_data(5, 0);
        run_conv(5, 1, 2, 0, 2, 1'b0, 1'b0, 12, "abort");
        run_conv(5, 1, 2, 0, 1, 1'b1, 1'b0, 0, "after abort eng1");

        run_illegal(2, 2, "M too small");
        run_illegal(11, 2, "M too large");
        run_illegal(5, 0, "zero engines");
        run_illegal(5, 3, "too many engines");

        for (int r = 0; r < 6; r++) begin
            int s, n, m, sh, relu, eng;
            s    = int'($urandom_range(1, 3));
            n    = int'($urandom_range(1, (MMAX - K) / s + 1));
            m    = (n - 1) * s + K;
            sh   = int'($urandom_range(0, 10));
            relu = int'($urandom_range(0, 1));
            eng  = int'($urandom_range(1, E));
            set_weights(1'b1);
            set_data(m, 2);
            run_conv(m, s, sh, relu, eng, 1'b1, 1'b0, 0, $sformatf("random run%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
